seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
- Parametrised Moore-style sequence detector; successor to the fixed 3-symbol 01→10→11 detector.
- Watches a stream of SYM_W-bit symbols and pulses `ans` when the last `len` accepted symbols equal a run-time programmable pattern of up to MAX_LEN symbols.
- Adds input-valid gating, overlap / non-overlap modes and a saturating match counter.
- Sits between the stimulus/input decode logic and any consumer of match events.

Parameters:
- SYM_W, 2, bits per symbol.
- MAX_LEN, 8, maximum pattern length in symbols (≥2).
- CNT_W, 8, width of match counter.
- DEF_LEN, 3, pattern length loaded at reset.
- DEF_PATTERN, 16'h0039, reset pattern, symbol 0 in LSBs; default = 01,10,11 (width MAX_LEN*SYM_W).
- DEF_OVERLAP, 1, overlap mode at reset.

Ports:
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-high; clears all state immediately.
- in_valid, in, 1, `num` accepted on this edge when 1.
- num, in, SYM_W, input symbol.
- cfg_load, in, 1, latch `cfg_*` on this edge.
- cfg_pattern, in, MAX_LEN*SYM_W, pattern; symbol i at bits [i*SYM_W +: SYM_W], symbol 0 is the first of the sequence.
- cfg_len, in, $clog2(MAX_LEN+1), pattern length.
- cfg_overlap, in, 1, 1 = overlapping matches allowed.
- ans, out, 1, registered one-cycle match pulse.
- match_cnt, out, CNT_W, saturating count of matches.

Behaviour:
- Reset (async, active-high):
  - hist = 0, fill = 0, ans = 0, match_cnt = 0.
  - pattern/len/overlap = DEF_PATTERN/DEF_LEN/DEF_OVERLAP.
  - Outputs go to reset values without waiting for a clock edge; normal operation resumes on the first edge after `reset` deasserts.
  - Reset mid-sequence discards partial matches.
- History:
  - hist[0..MAX_LEN-1] holds accepted symbols, hist[0] newest.
  - fill counts accepted symbols since the last clear and saturates at MAX_LEN.
- Accept edge (in_valid=1, cfg_load=0):
  - hist_n = {hist shifted by one, num at [0]}; fill_n = min(fill+1, MAX_LEN).
  - match = (len≠0) && (fill_n ≥ len) && hist_n[len-1-i] == pattern[i] for all i < len.
- Registered updates on the accept edge:
  - ans <= match. `ans` is high for exactly the one cycle following the completing edge; latency 1 edge, matching the original Moore output timing.
  - If match, match_cnt <= match_cnt+1, holding at 2^CNT_W-1 (no wrap).
  - Overlap mode: fill <= fill_n; the trailing symbols of a match may begin the next match.
  - Non-overlap mode on match: fill <= 0; hist is still shifted, but the next match needs `len` fresh symbols.
- Idle edge (in_valid=0, cfg_load=0): hist, fill and match_cnt hold; ans <= 0.
- cfg_load edge:
  - pattern, overlap <= inputs.
  - len <= min(cfg_len, MAX_LEN).
  - fill <= 0, ans <= 0, match_cnt <= 0.
  - cfg_load has priority: a simultaneous in_valid symbol is dropped.
- len = 0: detection disabled; ans stays 0 and the counter holds.
- len = 1: every symbol equal to pattern[0] pulses ans on consecutive cycles, in either mode.
- fill is compared against len, not MAX_LEN, so the first match after a clear can occur on the len-th accepted symbol.

Decomposition:
- Shared package (seq_det_pkg):
  - SYM_W/MAX_LEN defaults.
  - LEN_W = $clog2(MAX_LEN+1).
  - Default pattern constant and the named symbol constants S_01, S_10, S_11.
- One sub-module, seq_history:
  - Contains the shift register plus saturating fill counter, with shift, clear and async reset inputs.
  - Exposes hist_n and fill_n combinationally.
- Top level holds config registers, comparator, ans and match_cnt.

Test Plan:
- Reset defaults; stream 01,10,11,00 with in_valid=1 → ans=1 only in the cycle after the 11 edge; match_cnt=1.
- cfg_load pattern 01,01 (len 2), overlap=1; stream 01,01,01 → ans high after symbols 2 and 3, match_cnt=2. Repeat with overlap=0 → ans only after symbol 2, match_cnt=1.
- Default pattern; stream 01, gap, 10, gap, gap, 11 with in_valid=0 during gaps → ans pulses once after 11; ans=0 in all gap cycles.
- Stream 01,10, then cfg_load (same pattern) asserted together with in_valid and num=11 → no ans, fill=0, match_cnt=0; next stream 01,10,11 → one pulse.
- Stream 01,10; assert reset mid-cycle before the 11 edge → ans and match_cnt go 0 immediately; 11 after release → no match.
- CNT_W=2, len=1, pattern 11; six consecutive 11s → ans high for six cycles; match_cnt 1,2,3,3,3,3.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared constants for the parametrised sequence detector: default sizes,
// named symbols and the reset pattern 01 -> 10 -> 11.
package seq_det_pkg;

    localparam int SYM_W_DEF   = 2;
    localparam int MAX_LEN_DEF = 8;
    localparam int LEN_W       = $clog2(MAX_LEN_DEF + 1);

    localparam logic [SYM_W_DEF-1:0] S_01 = 2'b01;
    localparam logic [SYM_W_DEF-1:0] S_10 = 2'b10;
    localparam logic [SYM_W_DEF-1:0] S_11 = 2'b11;

    // Symbol 0 sits in the LSBs, so the first expected symbol is rightmost.
    localparam logic [MAX_LEN_DEF*SYM_W_DEF-1:0] PATTERN_01_10_11 =
        {{((MAX_LEN_DEF - 3) * SYM_W_DEF){1'b0}}, S_11, S_10, S_01};

endpackage

// File: rtl/seq_history.sv
// Symbol history shift register (slot 0 newest) with a fill counter that
// saturates at MAX_LEN; next-state values are exposed for the comparator.
module seq_history #(
    parameter int SYM_W   = 2,
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     shift,
    input  logic                     clear,
    input  logic [SYM_W-1:0]         num,
    output logic [MAX_LEN*SYM_W-1:0] hist_n,
    output logic [LEN_W-1:0]         fill_n
);

    logic [MAX_LEN*SYM_W-1:0] hist_reg;
    logic [LEN_W-1:0]         fill_reg;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_shift
            if (gi == 0) begin : g_head
                assign hist_n[0 +: SYM_W] = num;
            end else begin : g_body
                assign hist_n[gi*SYM_W +: SYM_W] = hist_reg[(gi-1)*SYM_W +: SYM_W];
            end
        end
    endgenerate

    assign fill_n = (fill_reg == LEN_W'(MAX_LEN)) ? fill_reg : fill_reg + 1'b1;

    // clear wins over the fill increment but never blocks the history shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_reg <= '0;
            fill_reg <= '0;
        end else begin
            if (shift) begin
                hist_reg <= hist_n;
            end
            if (clear) begin
                fill_reg <= '0;
            end else if (shift) begin
                fill_reg <= fill_n;
            end
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable sequence detector: pulses ans one cycle after the last len
// accepted symbols equal the loaded pattern, and counts matches (saturating).
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int                                SYM_W       = SYM_W_DEF,
    parameter int                                MAX_LEN     = MAX_LEN_DEF,
    parameter int                                CNT_W       = 8,
    parameter int                                DEF_LEN     = 3,
    parameter logic [MAX_LEN*SYM_W-1:0]          DEF_PATTERN = PATTERN_01_10_11,
    parameter logic                              DEF_OVERLAP = 1'b1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    input  logic [SYM_W-1:0]                  num,
    input  logic                              cfg_load,
    input  logic [MAX_LEN*SYM_W-1:0]          cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0]      cfg_len,
    input  logic                              cfg_overlap,
    output logic                              ans,
    output logic [CNT_W-1:0]                  match_cnt
);

    localparam int LEN_BITS = $clog2(MAX_LEN + 1);

    logic [MAX_LEN*SYM_W-1:0] pattern_reg;
    logic [LEN_BITS-1:0]      len_reg;
    logic                     overlap_reg;
    logic                     ans_reg;
    logic [CNT_W-1:0]         cnt_reg;

    logic [MAX_LEN*SYM_W-1:0] hist_n;
    logic [LEN_BITS-1:0]      fill_n;
    logic                     accept;
    logic                     seq_equal;
    logic                     match;
    logic [SYM_W-1:0]         sel_sym;

    assign accept = in_valid & ~cfg_load;

    seq_history #(
        .SYM_W   (SYM_W),
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_BITS)
    ) u_history (
        .clk    (clk),
        .reset  (reset),
        .shift  (accept),
        .clear  (cfg_load | (match & ~overlap_reg)),
        .num    (num),
        .hist_n (hist_n),
        .fill_n (fill_n)
    );

    // Pattern symbol i must sit at history slot len-1-i (oldest first).
    always_comb begin
        seq_equal = 1'b1;
        sel_sym   = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            sel_sym = '0;
            for (int j = 0; j < MAX_LEN; j++) begin
                if (j == int'(len_reg) - 1 - i) begin
                    sel_sym = hist_n[j*SYM_W +: SYM_W];
                end
            end
            if (i < int'(len_reg) && sel_sym != pattern_reg[i*SYM_W +: SYM_W]) begin
                seq_equal = 1'b0;
            end
        end
    end

    assign match = accept && (len_reg != '0) && (fill_n >= len_reg) && seq_equal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pattern_reg <= DEF_PATTERN;
            len_reg     <= LEN_BITS'(DEF_LEN);
            overlap_reg <= DEF_OVERLAP;
            ans_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else if (cfg_load) begin
            pattern_reg <= cfg_pattern;
            len_reg     <= (cfg_len > LEN_BITS'(MAX_LEN)) ? LEN_BITS'(MAX_LEN) : cfg_len;
            overlap_reg <= cfg_overlap;
            ans_reg     <= 1'b0;
            cnt_reg     <= '0;
        end else begin
            ans_reg <= match;
            if (match && cnt_reg != '1) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign ans       = ans_reg;
    assign match_cnt = cnt_reg;

endmodule

// File: tb/tb_seq_detector_param.sv
// Bench for seq_detector_param: directed scenarios plus random traffic, all
// compared against a queue-based model of the detection rules.
module tb_seq_detector_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  num;
    logic        cfg_load;
    logic [15:0] cfg_pattern;
    logic [3:0]  cfg_len;
    logic        cfg_overlap;
    logic        ans;
    logic [7:0]  match_cnt;
    logic        ans_b;
    logic [1:0]  match_cnt_b;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_detector_param dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .num(num),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .ans(ans), .match_cnt(match_cnt)
    );

    seq_detector_param #(.CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .num(num),
        .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .ans(ans_b), .match_cnt(match_cnt_b)
    );

    // Reference model: recent symbols (newest first) and a fresh-symbol count.
    int m_pat[8];
    int m_len;
    bit m_ovl;
    int m_hist[$];
    int m_fresh;
    bit m_ans;
    int m_cnt8;
    int m_cnt2;

    task automatic model_load(input logic [15:0] p, input int l, input bit o);
        for (int i = 0; i < 8; i++) m_pat[i] = int'(p[2*i +: 2]);
        m_len   = (l > 8) ? 8 : l;
        m_ovl   = o;
        m_fresh = 0;
        m_ans   = 1'b0;
        m_cnt8  = 0;
        m_cnt2  = 0;
    endtask

    task automatic model_reset();
        model_load(16'h0039, 3, 1'b1);
        m_hist.delete();
    endtask

    task automatic model_edge(input bit v, input int n, input bit ld,
                              input logic [15:0] p, input int l, input bit o);
        bit hit;
        if (ld) begin
            model_load(p, l, o);
        end else if (v) begin
            m_hist.push_front(n);
            if (m_hist.size() > 8) void'(m_hist.pop_back());
            m_fresh++;
            hit = (m_len > 0) && (m_fresh >= m_len);
            if (hit) begin
                for (int i = 0; i < m_len; i++)
                    if (m_hist[m_len-1-i] != m_pat[i]) hit = 1'b0;
            end
            m_ans = hit;
            if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!m_ovl) m_fresh = 0;
            end
        end else begin
            m_ans = 1'b0;
        end
    endtask

    task automatic check(input string tag);
        tests++;
        assert (ans === m_ans) else begin
            fails++;
            $error("FAIL %s ans got %0b expected %0b", tag, ans, m_ans);
        end
        tests++;
        assert (match_cnt === 8'(m_cnt8)) else begin
            fails++;
            $error("FAIL %s match_cnt got %0d expected %0d", tag, match_cnt, m_cnt8);
        end
        tests++;
        assert (match_cnt_b === 2'(m_cnt2)) else begin
            fails++;
            $error("FAIL %s match_cnt_b got %0d expected %0d", tag, match_cnt_b, m_cnt2);
        end
    endtask

    task automatic run_edge(input bit v, input logic [1:0] n, input bit ld,
                            input logic [15:0] p, input int l, input bit o,
                            input string tag);
        in_valid    = v;
        num         = n;
        cfg_load    = ld;
        cfg_pattern = p;
        cfg_len     = 4'(l);
        cfg_overlap = o;
        @(posedge clk);
        model_edge(v, int'(n), ld, p, l, o);
        #1;
        $display("[TB] %s v=%0b num=%0d ld=%0b ans=%0b cnt=%0d cnt_b=%0d",
                 tag, v, n, ld, ans, match_cnt, match_cnt_b);
        check(tag);
    endtask

    task automatic sym(input bit v, input logic [1:0] n, input string tag);
        run_edge(v, n, 1'b0, 16'h0, 0, 1'b0, tag);
    endtask

    task automatic cfg(input logic [15:0] p, input int l, input bit o, input string tag);
        run_edge(1'b0, 2'b00, 1'b1, p, l, o, tag);
    endtask

    int exp_sat[6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        reset = 1'b1; in_valid = 1'b0; num = '0; cfg_load = 1'b0;
        cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
        model_reset();
        #3;
        check("reset");
        @(negedge clk);
        reset = 1'b0;

        // Default pattern 01,10,11
        sym(1, 2'b01, "def_s1"); sym(1, 2'b10, "def_s2");
        sym(1, 2'b11, "def_s3"); sym(1, 2'b00, "def_s4");

        // Pattern 01,01 overlapping, then non-overlapping
        cfg(16'h0005, 2, 1'b1, "ov_cfg");
        for (int i = 0; i < 3; i++) sym(1, 2'b01, "ov_sym");
        cfg(16'h0005, 2, 1'b0, "nov_cfg");
        for (int i = 0; i < 3; i++) sym(1, 2'b01, "nov_sym");

        // Gaps with in_valid low
        cfg(16'h0039, 3, 1'b1, "gap_cfg");
        sym(1, 2'b01, "gap_s1"); sym(0, 2'b11, "gap_idle");
        sym(1, 2'b10, "gap_s2"); sym(0, 2'b11, "gap_idle");
        sym(0, 2'b11, "gap_idle"); sym(1, 2'b11, "gap_s3"); sym(0, 2'b00, "gap_idle");

        // cfg_load beats a simultaneous valid symbol
        sym(1, 2'b01, "pri_s1"); sym(1, 2'b10, "pri_s2");
        run_edge(1'b1, 2'b11, 1'b1, 16'h0039, 3, 1'b1, "pri_cfg");
        sym(1, 2'b01, "pri_s3"); sym(1, 2'b10, "pri_s4"); sym(1, 2'b11, "pri_s5");

        // Asynchronous reset mid-sequence
        sym(1, 2'b01, "rst_s1"); sym(1, 2'b10, "rst_s2");
        #2 reset = 1'b1;
        model_reset();
        #1 check("reset_async");
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sym(1, 2'b11, "rst_s3");

        // len=1, saturation of the 2-bit counter
        cfg(16'h0003, 1, 1'b0, "sat_cfg");
        for (int i = 0; i < 6; i++) begin
            sym(1, 2'b11, "sat_sym");
            tests++;
            assert (match_cnt_b === 2'(exp_sat[i])) else begin
                fails++;
                $error("FAIL sat_seq[%0d] match_cnt_b got %0d expected %0d",
                       i, match_cnt_b, exp_sat[i]);
            end
        end

        // len=0 disables; oversize len clamps to 8
        cfg(16'h0000, 0, 1'b1, "len0_cfg");
        for (int i = 0; i < 3; i++) sym(1, 2'b00, "len0_sym");
        cfg(16'h0000, 15, 1'b1, "clamp_cfg");
        for (int i = 0; i < 10; i++) sym(1, 2'b00, "clamp_sym");

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                cfg(16'($urandom), ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15))
                                                                 : int'($urandom_range(1, 3)),
                    1'($urandom), "rnd_cfg");
            end else begin
                sym(1'($urandom_range(0, 3) != 0), 2'($urandom), "rnd_sym");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
